// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keycode decoder.
// Holds the prefix/ignore scan codes, the hex-digit scan-code table, the
// prefix-parser state enum and the event-word layout.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0   = 8'hE0;
  localparam logic [7:0] SC_F0   = 8'hF0;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_DEL  = 8'h71;

  // Event word: {break, ext, code[7:0]}
  localparam int unsigned EV_W        = 10;
  localparam int unsigned EV_BRK_BIT  = 9;
  localparam int unsigned EV_EXT_BIT  = 8;
  localparam int unsigned EV_CODE_LSB = 0;

  // Scan codes of hex digits 0..f, indexed by digit value.
  localparam logic [7:0] HEX_SC [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } hex_lookup_t;

  // Controller/keyboard housekeeping bytes (ack, BAT, echo, resend, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic hex_lookup_t hex_lookup(input logic [7:0] code);
    hex_lookup_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (code == HEX_SC[i]) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   write request and data
//   pop_i            read request; honoured only when not empty
//   data_o, valid_o  head entry (0 when empty) and not-empty flag
//   overflow_o       sticky: a push was dropped because the FIFO was full
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic empty, full, pop_en, push_en;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    pop_en  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_en = push_i && (!full || pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_i && !push_en) overflow_q <= 1'b1;
    end
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 scan-code decoder: parses E0/F0 prefixes, tracks held hex digits,
// backspace and delete, strobes hex makes and queues make/break events.
// Ports:
//   CLOCK, reset            sole clock, synchronous active-high reset
//   rx_data, rx_valid       received scan byte and its one-cycle qualifier
//   numbers                 held state of hex keys 0..f
//   key_backspace/delete    held state of backspace (66) and delete (E0 71)
//   ev_data/valid/ready     FWFT event queue head {break, ext, code}
//   ev_overflow             sticky: an event was dropped
//   digit, digit_stb        last hex make and its one-cycle strobe
module ps2_keycode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic            CLOCK,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [15:0]     numbers,
  output logic            key_backspace,
  output logic            key_delete,
  output logic [EV_W-1:0] ev_data,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic            ev_overflow,
  output logic [3:0]      digit,
  output logic            digit_stb
);

  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e     state_q, state_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic [15:0]    numbers_q, numbers_d;
  logic           bksp_q, bksp_d;
  logic           del_q, del_d;
  logic [3:0]     digit_q, digit_d;
  logic           stb_q, stb_d;

  logic            emit, ev_brk, ev_ext, push, held;
  logic            is_hex, is_bksp, is_del;
  hex_lookup_t     hex;
  logic [EV_W-1:0] ev_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    numbers_d = numbers_q;
    bksp_d    = bksp_q;
    del_d     = del_q;
    digit_d   = digit_q;
    stb_d     = 1'b0;
    emit      = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;

    if (rx_valid) begin
      cnt_d = '0;
      if (is_ignored(rx_data)) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rx_data == SC_E0)      state_d = GOT_E0;
            else if (rx_data == SC_F0) state_d = GOT_F0;
            else                       emit    = 1'b1;
          end
          GOT_E0: begin
            if (rx_data == SC_F0) begin
              state_d = GOT_E0F0;
            end else if (rx_data != SC_E0) begin
              emit    = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_F0: begin
            if (rx_data == SC_E0) begin
              state_d = GOT_E0F0;
            end else if (rx_data != SC_F0) begin
              emit    = 1'b1;
              ev_brk  = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_E0F0: begin
            if (rx_data != SC_E0 && rx_data != SC_F0) begin
              emit    = 1'b1;
              ev_brk  = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // Abandon a dangling prefix when the rest of the sequence never arrives.
      if (cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TOW'(1);
      end
    end

    hex     = hex_lookup(rx_data);
    is_hex  = hex.hit && !ev_ext;
    is_bksp = !ev_ext && (rx_data == SC_BKSP);
    is_del  = ev_ext && (rx_data == SC_DEL);

    if (is_hex)       held = numbers_q[hex.idx];
    else if (is_bksp) held = bksp_q;
    else if (is_del)  held = del_q;
    else              held = 1'b0;

    // Typematic repeat of a held key is dropped unless repeats are enabled.
    push = emit && (ev_brk || REPEAT_EN || !held);

    if (emit) begin
      if (is_hex)  numbers_d[hex.idx] = !ev_brk;
      if (is_bksp) bksp_d = !ev_brk;
      if (is_del)  del_d = !ev_brk;
      if (is_hex && !ev_brk && push) begin
        digit_d = hex.idx;
        stb_d   = 1'b1;
      end
    end

    ev_word                          = '0;
    ev_word[EV_BRK_BIT]              = ev_brk;
    ev_word[EV_EXT_BIT]              = ev_ext;
    ev_word[EV_CODE_LSB +: 8]        = rx_data;
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      numbers_q <= '0;
      bksp_q    <= 1'b0;
      del_q     <= 1'b0;
      digit_q   <= '0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      numbers_q <= numbers_d;
      bksp_q    <= bksp_d;
      del_q     <= del_d;
      digit_q   <= digit_d;
      stb_q     <= stb_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk_i      (CLOCK),
    .rst_i      (reset),
    .push_i     (push),
    .data_i     (ev_word),
    .pop_i      (ev_ready),
    .data_o     (ev_data),
    .valid_o    (ev_valid),
    .overflow_o (ev_overflow)
  );

  assign numbers       = numbers_q;
  assign key_backspace = bksp_q;
  assign key_delete    = del_q;
  assign digit         = digit_q;
  assign digit_stb     = stb_q;

endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
- Clocked successor to the keyboard driver. Consumes the byte stream from mouse_Inner_controller (received_data / received_data_en) synchronously on CLOCK; it no longer clocks on the data strobe.
- Parses the E0 (extended) and F0 (release) prefixes with an explicit FSM and holds the state of the mapped keys (hex digits 0-9/a-f, backspace, delete).
- Adds a parametrised FIFO of make/break events, a hex-digit strobe, typematic-repeat suppression and a prefix timeout.
- Sits between the PS/2 receiver and the DES key/plaintext entry logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, >=2
TIMEOUT_CYCLES, 50000, CLOCK cycles without a byte before a pending prefix is abandoned (1 ms at 50 MHz)
REPEAT_EN, 0, 1 = typematic repeats of an already-held mapped key produce events/strobes; 0 = suppressed

Ports:
CLOCK  in  1  system clock; sole clock
reset  in  1  synchronous, active-high
rx_data  in  8  received scan byte
rx_valid  in  1  one-cycle pulse, synchronous to CLOCK, qualifies rx_data
numbers  out  16  held state of hex keys; bit i = digit i (0x45,16,1E,26,25,2E,36,3D,3E,46,1C,32,21,23,24,2B)
key_backspace  out  1  held state, non-extended 0x66
key_delete  out  1  held state, extended E0 0x71
ev_data  out  10  {break, ext, code[7:0]} at FIFO head
ev_valid  out  1  FIFO not empty
ev_ready  in  1  consumer pop; pop occurs when ev_valid && ev_ready
ev_overflow  out  1  sticky; an event was dropped
digit  out  4  index of last hex make
digit_stb  out  1  one-cycle pulse on hex make

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, timeout counter 0. Reset has priority; an rx_valid in the reset cycle is discarded.
- Ignored bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF. Each returns the FSM to IDLE and emits nothing.
- FSM, evaluated only when rx_valid=1:
  - IDLE: E0 -> GOT_E0. F0 -> GOT_F0. Other -> emit make(ext=0).
  - GOT_E0: F0 -> GOT_E0F0. E0 -> stay. Other -> emit make(ext=1), go to IDLE.
  - GOT_F0: E0 -> GOT_E0F0. F0 -> stay. Other -> emit break(ext=0), go to IDLE.
  - GOT_E0F0: E0/F0 -> stay. Other -> emit break(ext=1), go to IDLE.
- Timeout: the counter clears on each rx_valid. It increments while FSM != IDLE. On reaching TIMEOUT_CYCLES the FSM goes to IDLE and the counter clears.
- Emit latency: numbers, key_* and digit/digit_stb update, and the FIFO push occurs, on the clock edge that samples rx_valid. They are visible the next cycle.
- Mapping:
  - numbers and key_backspace respond to non-extended codes only.
  - key_delete responds to extended 0x71 only.
  - Make sets the bit; break clears it.
  - E0 45 does not touch numbers[0].
- Repeat rule (REPEAT_EN=0): a make for a mapped key whose bit is already 1 is not pushed and gives no digit_stb. Unmapped codes are always pushed. A break of a key not held is still pushed.
- digit_stb: on an accepted hex make. digit = bit index and is held until the next strobe.
- FIFO: first-word-fall-through; ev_data is valid whenever ev_valid=1.
  - Push while full with a simultaneous pop: push accepted, count unchanged.
  - Push while full without a pop: event dropped, ev_overflow <= 1.
  - ev_overflow clears only on reset.
  - Order is strict FIFO; pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits wide.
  - Pop while empty: no effect.

Decomposition:
- Package ps2_kbd_pkg holds:
  - constants SC_E0, SC_F0, SC_BKSP=8'h66, SC_DEL=8'h71, and the ignore list;
  - the 16-entry hex scan-code table;
  - the FSM state enum {IDLE, GOT_E0, GOT_F0, GOT_E0F0};
  - EV_W=10 and the event field positions.
- Sub-module ps2_event_fifo: synchronous FWFT FIFO with full-push-pop handling and sticky overflow; parameters DEPTH and WIDTH.

Test Plan:
- Reset, rx 0x16 -> next cycle: numbers=16'h0002, digit=1, digit_stb high for one cycle, ev_valid=1, ev_data={0,0,8'h16}.
- Then F0,16 -> numbers=16'h0000, event {1,0,8'h16}, no digit_stb. E0,45 -> event {0,1,8'h45}, numbers unchanged.
- E0,71 then E0,F0,71 -> key_delete 1 then 0; events {0,1,8'h71}, {1,1,8'h71}; no extra events from prefixes or from 0xAA/0xFA inserted between sequences.
- REPEAT_EN=0: 1E,1E,1E -> one event, one digit_stb (digit=2). REPEAT_EN=1: same stimulus -> three events, three strobes.
- FIFO_DEPTH=4, ev_ready=0, makes 15,1D,24,2D,2C -> four entries, ev_overflow=1, pop order 15,1D,24,2D. With FIFO full, push+pop in the same cycle -> accepted, overflow unchanged.
- TIMEOUT_CYCLES=100: F0, wait 100 idle cycles, then 0x1C -> make: numbers[10]=1, event {0,0,8'h1C}. F0 with 99-cycle gap then 0x1C -> break. Reset asserted mid E0F0 -> next 0x71 is a plain make.
